pipe_datapath: RTL and testbench

PIPE_DATAPATH -- requirements
Module: pipe_datapath

---
 rtl/pipe_datapath.sv | 245 ++++++++++++++++++++++++
 tb/tb_pipe_datapath.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_datapath.sv
// ============================================================================
//  Module   : pipe_datapath
//  Purpose  : Decode/execute slice of an in-order RISC-V style pipeline.
//             Holds the architectural register file, generates immediates,
//             carries one instruction in the EX pipeline register and
//             computes the ALU result, branch/jump target and store data.
//  Revision : 1.0  initial release
//
//  Parameters
//    XLEN       datapath / register width (32 or 64)
//    REG_COUNT  number of architectural registers (16 or 32)
//
//  Ports
//    clk            clock, rising edge
//    rst            synchronous active-low reset
//    instr_d        decode-stage instruction word
//    pc_d           decode-stage PC
//    valid_d        decode slot holds a real instruction
//    reg_write_d    decode instruction writes rd
//    alu_src_d      0 = rs2 operand, 1 = immediate
//    imm_src_d      immediate format 00 I, 01 S, 10 B, 11 J
//    alu_control_d  ALU operation select
//    stall          hold the EX register
//    flush          bubble the EX register (wins over stall)
//    reg_write_w    writeback enable
//    rd_w           writeback destination index
//    result_w       writeback data
//    valid_e        EX slot holds a real instruction
//    reg_write_e    EX instruction writes rd
//    rd_e           EX destination index
//    alu_result_e   ALU result
//    pc_target_e    EX pc + EX immediate
//    write_data_e   (forwarded) rs2 value, used as store data
//    zflag_e        alu_result_e == 0
//
//  Build option
//    DATAPATH_FWD_EN  when defined, EX operands are forwarded from the
//                     writeback port on an index match.
// ============================================================================
`default_nettype none

module pipe_datapath #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            valid_d,
  input  logic            reg_write_d,
  input  logic            alu_src_d,
  input  logic [1:0]      imm_src_d,
  input  logic [3:0]      alu_control_d,
  input  logic            stall,
  input  logic            flush,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] alu_result_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] write_data_e,
  output logic            zflag_e
);

  localparam int IDXW = $clog2(REG_COUNT);
  localparam int SHW  = $clog2(XLEN);

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b0001;
  localparam logic [3:0] c_ALU_AND  = 4'b0010;
  localparam logic [3:0] c_ALU_OR   = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_SLT  = 4'b0101;
  localparam logic [3:0] c_ALU_SLTU = 4'b0110;
  localparam logic [3:0] c_ALU_SLL  = 4'b0111;
  localparam logic [3:0] c_ALU_SRL  = 4'b1000;
  localparam logic [3:0] c_ALU_SRA  = 4'b1001;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [REG_COUNT];

  // Index bits above IDXW are ignored everywhere, so a writeback to e.g.
  // x16 on a 16-entry file aliases x0 and is dropped.
  logic [IDXW-1:0] w_wb_idx;
  logic            w_wb_en;
  assign w_wb_idx = rd_w[IDXW-1:0];
  assign w_wb_en  = reg_write_w && (w_wb_idx != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[w_wb_idx] <= result_w;
    end
  end

  // Decode-stage reads with write-before-read bypass from the writeback port.
  logic [IDXW-1:0] w_rs1_idx;
  logic [IDXW-1:0] w_rs2_idx;
  logic [XLEN-1:0] w_rs1_d;
  logic [XLEN-1:0] w_rs2_d;

  assign w_rs1_idx = instr_d[15 +: IDXW];
  assign w_rs2_idx = instr_d[20 +: IDXW];

  always_comb begin
    w_rs1_d = '0;
    w_rs2_d = '0;
    if (w_rs1_idx != '0) begin
      w_rs1_d = (w_wb_en && (w_wb_idx == w_rs1_idx)) ? result_w : r_regs[w_rs1_idx];
    end
    if (w_rs2_idx != '0) begin
      w_rs2_d = (w_wb_en && (w_wb_idx == w_rs2_idx)) ? result_w : r_regs[w_rs2_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Immediate generation (sign-extended to XLEN)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_imm_d;

  always_comb begin
    w_imm_d = '0;
    case (imm_src_d)
      2'b00: w_imm_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
      2'b01: w_imm_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      2'b10: w_imm_d = {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7],
                        instr_d[30:25], instr_d[11:8], 1'b0};
      default: w_imm_d = {{(XLEN-21){instr_d[31]}}, instr_d[31], instr_d[19:12],
                          instr_d[20], instr_d[30:21], 1'b0};
    endcase
  end

  // --------------------------------------------------------------------------
  // EX pipeline register
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1_idx;
  logic [4:0]      r_rs2_idx;
  logic [4:0]      r_rd;
  logic            r_alu_src;
  logic [3:0]      r_alu_ctrl;
  logic            r_valid;
  logic            r_reg_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_rs1_idx   <= '0;
      r_rs2_idx   <= '0;
      r_rd        <= '0;
      r_alu_src   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      // Only the tags need killing; the payload is don't-care for a bubble.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_rs1_val   <= w_rs1_d;
      r_rs2_val   <= w_rs2_d;
      r_imm       <= w_imm_d;
      r_pc        <= pc_d;
      r_rs1_idx   <= instr_d[19:15];
      r_rs2_idx   <= instr_d[24:20];
      r_rd        <= instr_d[11:7];
      r_alu_src   <= alu_src_d;
      r_alu_ctrl  <= alu_control_d;
      r_valid     <= valid_d;
      r_reg_write <= reg_write_d;
    end
  end

  // --------------------------------------------------------------------------
  // EX operand selection
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b;

`ifdef DATAPATH_FWD_EN
  assign w_src_a = (w_wb_en && (w_wb_idx == r_rs1_idx[IDXW-1:0])) ? result_w : r_rs1_val;
  assign w_src_b = (w_wb_en && (w_wb_idx == r_rs2_idx[IDXW-1:0])) ? result_w : r_rs2_val;
`else
  assign w_src_a = r_rs1_val;
  assign w_src_b = r_rs2_val;
`endif

  logic [XLEN-1:0] w_op_b;
  logic [SHW-1:0]  w_shamt;
  assign w_op_b  = r_alu_src ? r_imm : w_src_b;
  assign w_shamt = w_op_b[SHW-1:0];

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_alu;

  always_comb begin
    w_alu = '0;
    case (r_alu_ctrl)
      c_ALU_ADD:  w_alu = w_src_a + w_op_b;
      c_ALU_SUB:  w_alu = w_src_a - w_op_b;
      c_ALU_AND:  w_alu = w_src_a & w_op_b;
      c_ALU_OR:   w_alu = w_src_a | w_op_b;
      c_ALU_XOR:  w_alu = w_src_a ^ w_op_b;
      c_ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_op_b))};
      c_ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_src_a < w_op_b)};
      c_ALU_SLL:  w_alu = w_src_a << w_shamt;
      c_ALU_SRL:  w_alu = w_src_a >> w_shamt;
      c_ALU_SRA:  w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
      default:    w_alu = '0;
    endcase
  end

  assign valid_e      = r_valid;
  assign reg_write_e  = r_reg_write;
  assign rd_e         = r_rd;
  assign alu_result_e = w_alu;
  assign pc_target_e  = r_pc + r_imm;
  assign write_data_e = w_src_b;
  assign zflag_e      = (w_alu == '0);

  // Opcode/funct3 are decoded by the controller; the source index copies are
  // only consumed when forwarding is built in.
  logic w_unused;
  assign w_unused = ^{instr_d[14:12], instr_d[6:0], rd_w, r_rs1_idx, r_rs2_idx};

endmodule

`default_nettype wire

// File: tb/tb_pipe_datapath.sv
// ============================================================================
//  Module   : tb_pipe_datapath
//  Purpose  : Directed self-checking bench for pipe_datapath (XLEN=32,
//             REG_COUNT=32). Expectations honour DATAPATH_FWD_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_datapath;

`ifdef DATAPATH_FWD_EN
  localparam bit c_FWD = 1'b1;
`else
  localparam bit c_FWD = 1'b0;
`endif

  localparam logic [3:0] c_ADD  = 4'd0;
  localparam logic [3:0] c_SUB  = 4'd1;
  localparam logic [3:0] c_AND  = 4'd2;
  localparam logic [3:0] c_OR   = 4'd3;
  localparam logic [3:0] c_XOR  = 4'd4;
  localparam logic [3:0] c_SLT  = 4'd5;
  localparam logic [3:0] c_SLTU = 4'd6;
  localparam logic [3:0] c_SLL  = 4'd7;
  localparam logic [3:0] c_SRL  = 4'd8;
  localparam logic [3:0] c_SRA  = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        reg_write_d;
  logic        alu_src_d;
  logic [1:0]  imm_src_d;
  logic [3:0]  alu_control_d;
  logic        stall;
  logic        flush;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        valid_e;
  logic        reg_write_e;
  logic [4:0]  rd_e;
  logic [31:0] alu_result_e;
  logic [31:0] pc_target_e;
  logic [31:0] write_data_e;
  logic        zflag_e;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_datapath #(.XLEN(32), .REG_COUNT(32)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .valid_d       (valid_d),
    .reg_write_d   (reg_write_d),
    .alu_src_d     (alu_src_d),
    .imm_src_d     (imm_src_d),
    .alu_control_d (alu_control_d),
    .stall         (stall),
    .flush         (flush),
    .reg_write_w   (reg_write_w),
    .rd_w          (rd_w),
    .result_w      (result_w),
    .valid_e       (valid_e),
    .reg_write_e   (reg_write_e),
    .rd_e          (rd_e),
    .alu_result_e  (alu_result_e),
    .pc_target_e   (pc_target_e),
    .write_data_e  (write_data_e),
    .zflag_e       (zflag_e)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] btype(input logic [12:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jtype(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // One clock: capture on the edge, then drop the one-shot writeback and let
  // combinational outputs settle before any check.
  task automatic tick();
    @(posedge clk);
    #1;
    reg_write_w = 1'b0;
    #1;
  endtask

  task automatic dec(input logic [31:0] ins, input logic [3:0] ctl, input logic src,
                     input logic [1:0] isrc);
    instr_d       = ins;
    alu_control_d = ctl;
    alu_src_d     = src;
    imm_src_d     = isrc;
    valid_d       = 1'b1;
    reg_write_d   = 1'b1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] v);
    reg_write_w = 1'b1;
    rd_w        = rd;
    result_w    = v;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_e}, 32'd0);
    chk({tag, "_rw"},    {31'b0, reg_write_e}, 32'd0);
    chk({tag, "_rd"},    {27'b0, rd_e}, 32'd0);
    chk({tag, "_alu"},   alu_result_e, 32'd0);
    chk({tag, "_pct"},   pc_target_e, 32'd0);
    chk({tag, "_wd"},    write_data_e, 32'd0);
    chk({tag, "_z"},     {31'b0, zflag_e}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; instr_d = '0; pc_d = '0; valid_d = 1'b0; reg_write_d = 1'b0;
    alu_src_d = 1'b0; imm_src_d = 2'b00; alu_control_d = 4'd0;
    stall = 1'b0; flush = 1'b0; reg_write_w = 1'b0; rd_w = '0; result_w = '0;

    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b1;

    // ADDI x6,x5,3 decoded while x5=7 is written back (decode bypass)
    wb(5'd5, 32'd7);
    dec(itype(12'd3, 5'd5, 5'd6), c_ADD, 1'b1, 2'b00);
    tick();
    chk("addi_alu", alu_result_e, 32'd10);
    chk("addi_rd", {27'b0, rd_e}, 32'd6);
    chk("addi_z", {31'b0, zflag_e}, 32'd0);
    chk("addi_valid", {31'b0, valid_e}, 32'd1);
    chk("addi_rw", {31'b0, reg_write_e}, 32'd1);

    // SUB x8,x5,x5 from the register file
    dec(rtype(5'd5, 5'd5, 5'd8), c_SUB, 1'b0, 2'b00);
    tick();
    chk("sub_alu", alu_result_e, 32'd0);
    chk("sub_z", {31'b0, zflag_e}, 32'd1);
    chk("sub_wd", write_data_e, 32'd7);

    // ADD x7,x5,x5 in EX, then writeback x5=100 in the same cycle
    dec(rtype(5'd5, 5'd5, 5'd7), c_ADD, 1'b0, 2'b00);
    tick();
    chk("add_pre", alu_result_e, 32'd14);
    wb(5'd5, 32'd100);
    #1;
    chk("fwd_alu", alu_result_e, c_FWD ? 32'd200 : 32'd14);
    chk("fwd_wd", write_data_e, c_FWD ? 32'd100 : 32'd7);

    // x5=100 committed on this edge
    dec(rtype(5'd0, 5'd5, 5'd9), c_ADD, 1'b0, 2'b00);
    tick();
    chk("rf_x5", alu_result_e, 32'd100);

    // Stall two cycles, then flush with stall held
    dec(itype(12'd42, 5'd0, 5'd10), c_ADD, 1'b1, 2'b00);
    tick();
    chk("pre_stall", alu_result_e, 32'd42);
    stall = 1'b1;
    dec(itype(12'd5, 5'd0, 5'd11), c_ADD, 1'b1, 2'b00);
    tick();
    chk("stall1_alu", alu_result_e, 32'd42);
    chk("stall1_rd", {27'b0, rd_e}, 32'd10);
    tick();
    chk("stall2_alu", alu_result_e, 32'd42);
    chk("stall2_valid", {31'b0, valid_e}, 32'd1);
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, valid_e}, 32'd0);
    chk("flush_rw", {31'b0, reg_write_e}, 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    // B-type imm -8 at pc 0x100
    pc_d = 32'h100;
    dec(btype(13'h1FF8, 5'd0, 5'd0), c_ADD, 1'b0, 2'b10);
    tick();
    chk("b_target", pc_target_e, 32'h0000_00F8);

    // J-type imm +2048 at pc 0x200
    pc_d = 32'h200;
    dec(jtype(21'd2048, 5'd1), c_ADD, 1'b1, 2'b11);
    tick();
    chk("j_target", pc_target_e, 32'h0000_0A00);
    chk("j_alu", alu_result_e, 32'h0000_0800);

    // S-type imm -5 through the ALU
    dec(stype(12'hFFB, 5'd0, 5'd0), c_ADD, 1'b1, 2'b01);
    tick();
    chk("s_imm", alu_result_e, 32'hFFFF_FFFB);

    // Shifts on x12 = 0x8000_0000 (bypassed into decode)
    wb(5'd12, 32'h8000_0000);
    dec(itype(12'd4, 5'd12, 5'd15), c_SRA, 1'b1, 2'b00);
    tick();
    chk("sra", alu_result_e, 32'hF800_0000);
    dec(itype(12'd4, 5'd12, 5'd16), c_SRL, 1'b1, 2'b00);
    tick();
    chk("srl", alu_result_e, 32'h0800_0000);
    dec(itype(12'h022, 5'd5, 5'd17), c_SLL, 1'b1, 2'b00);
    tick();
    chk("sll_mask", alu_result_e, 32'd400);

    // Comparisons
    dec(itype(12'hFFF, 5'd5, 5'd18), c_SLT, 1'b1, 2'b00);
    tick();
    chk("slt_pos_neg", alu_result_e, 32'd0);
    dec(itype(12'hFFF, 5'd5, 5'd18), c_SLTU, 1'b1, 2'b00);
    tick();
    chk("sltu", alu_result_e, 32'd1);
    dec(itype(12'd0, 5'd12, 5'd19), c_SLT, 1'b1, 2'b00);
    tick();
    chk("slt_neg_zero", alu_result_e, 32'd1);

    // Logic ops on x5 = 0x64
    dec(itype(12'h00F, 5'd5, 5'd20), c_AND, 1'b1, 2'b00);
    tick();
    chk("and", alu_result_e, 32'd4);
    dec(itype(12'h00F, 5'd5, 5'd20), c_OR, 1'b1, 2'b00);
    tick();
    chk("or", alu_result_e, 32'h6F);
    dec(itype(12'h0FF, 5'd5, 5'd20), c_XOR, 1'b1, 2'b00);
    tick();
    chk("xor", alu_result_e, 32'h9B);
    dec(itype(12'h0FF, 5'd5, 5'd20), 4'hF, 1'b1, 2'b00);
    tick();
    chk("undef_op", alu_result_e, 32'd0);
    chk("undef_z", {31'b0, zflag_e}, 32'd1);

    // Writeback to x0 must be invisible to bypass and register file
    wb(5'd0, 32'd55);
    dec(rtype(5'd0, 5'd0, 5'd1), c_ADD, 1'b0, 2'b00);
    tick();
    chk("x0_bypass", alu_result_e, 32'd0);
    dec(rtype(5'd0, 5'd0, 5'd1), c_OR, 1'b0, 2'b00);
    tick();
    chk("x0_read", alu_result_e, 32'd0);
    chk("x0_wd", write_data_e, 32'd0);

    // Mid-stream reset with a concurrent writeback
    rst = 1'b0;
    wb(5'd13, 32'd77);
    dec(itype(12'd1, 5'd5, 5'd13), c_ADD, 1'b1, 2'b00);
    tick();
    chk_reset_state("mrst");
    rst = 1'b1;
    dec(rtype(5'd0, 5'd13, 5'd14), c_ADD, 1'b0, 2'b00);
    tick();
    chk("mrst_x13", alu_result_e, 32'd0);
    chk("mrst_rd", {27'b0, rd_e}, 32'd14);
    dec(itype(12'd1, 5'd5, 5'd14), c_ADD, 1'b1, 2'b00);
    tick();
    chk("mrst_x5", alu_result_e, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
